// File: rtl/lut_neuron_stream_if.sv
// Streaming and configuration signals of the LUT neuron, bundled for port use.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. The producer holds data and valid stable while valid && !ready.
// The consumer may raise or drop ready at any time, and ready may depend
// combinationally on the other side's ready.
interface lut_neuron_stream_if #(
    parameter int FANIN  = 4,
    parameter int IN_BW  = 2,
    parameter int OUT_BW = 2
);
    localparam int ADDR_W = FANIN * IN_BW;

    logic [ADDR_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_BW-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [OUT_BW-1:0] cfg_data;
    logic              cfg_ready;
    logic              init_done;
    logic              dbg_state;   // FSM state: 0 = INIT, 1 = RUN

    modport master (
        output in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_data, out_valid, cfg_ready, init_done, dbg_state
    );

    modport slave (
        input  in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_data, out_valid, cfg_ready, init_done, dbg_state
    );
endinterface

// File: rtl/lut_neuron_stream.sv
// Runtime-programmable LUT neuron: the concatenated quantised inputs address
// a truth table. One output register stage, valid/ready on both sides.
// After reset an INIT phase fills every entry with DEFAULT_OUT; the block
// then stays in RUN, where the table can be rewritten through the cfg port.
module lut_neuron_stream #(
    parameter int                FANIN       = 4,
    parameter int                IN_BW       = 2,
    parameter int                OUT_BW      = 2,
    parameter logic [OUT_BW-1:0] DEFAULT_OUT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    lut_neuron_stream_if.slave     bus
);
    localparam int ADDR_W = FANIN * IN_BW;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [OUT_BW-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    // Truth table storage; contents are only ever set by the INIT sweep
    // or by config writes, never by reset.
    logic [OUT_BW-1:0] table_q [DEPTH];
    logic              tbl_we_d;
    logic [ADDR_W-1:0] tbl_waddr_d;
    logic [OUT_BW-1:0] tbl_wdata_d;

    logic run;
    logic in_ready;
    logic accept;

    // Next-state: INIT walks the counter across the whole table, then RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Table write port: the init sweep owns it in INIT, cfg writes in RUN.
    always_comb begin
        tbl_we_d    = 1'b0;
        tbl_waddr_d = '0;
        tbl_wdata_d = '0;
        if (state_q == ST_INIT) begin
            tbl_we_d    = 1'b1;
            tbl_waddr_d = cnt_q;
            tbl_wdata_d = DEFAULT_OUT;
        end else if (bus.cfg_we) begin
            tbl_we_d    = 1'b1;
            tbl_waddr_d = bus.cfg_addr;
            tbl_wdata_d = bus.cfg_data;
        end
    end

    // Output stage: load on accept, hold while stalled, drop when drained.
    // The lookup reads the table before this edge's write lands, so a
    // same-cycle write to the looked-up address returns the old value.
    always_comb begin
        run         = (state_q == ST_RUN);
        in_ready    = run && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && in_ready;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = table_q[bus.in_data];
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Table write; suppressed while rst is high so reset never writes.
    always_ff @(posedge clk) begin
        if (!rst && tbl_we_d) begin
            table_q[tbl_waddr_d] <= tbl_wdata_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cfg_ready = run;
    assign bus.init_done = run;
    assign bus.dbg_state = logic'(state_q);
endmodule

// File: tb/tb_lut_neuron_stream.sv
// Bench for lut_neuron_stream: drivers issue beats and cfg writes, a
// negedge monitor keeps a plain-array table model, queues the expected
// activation at every accepted lookup and compares at every output beat.
module tb_lut_neuron_stream;
    localparam int W      = 2;
    localparam int AW     = 8;
    localparam int DEPTH  = 256;
    localparam logic [W-1:0] DEF = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lut_neuron_stream_if #(.FANIN(4), .IN_BW(2), .OUT_BW(2)) bus ();

    lut_neuron_stream #(.FANIN(4), .IN_BW(2), .OUT_BW(2), .DEFAULT_OUT(DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_s = 1'b1;   // rst as sampled by the most recent rising edge
    initial forever begin
        @(posedge clk);
        rst_s = rst;
        cyc   = cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc[$];
    logic [W-1:0] model_tbl [DEPTH];
    bit           model_run = 1'b0;
    int           model_cnt = 0;
    int           n_checks  = 0;
    int           n_pass    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- monitor / reference model ----------------
    initial begin
        logic [W-1:0] e;
        bit exp_rdy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_s) begin
                for (int i = 0; i < DEPTH; i++) model_tbl[i] = DEF;
                exp_q.delete();
                model_run = 1'b0;
                model_cnt = 0;
                check("reset_outputs",
                      int'({bus.out_valid, bus.in_ready, bus.cfg_ready, bus.init_done}), 0);
            end else begin
                if (!model_run) begin
                    model_cnt++;
                    if (model_cnt == DEPTH) model_run = 1'b1;
                end
                exp_rdy = model_run && (!bus.out_valid || bus.out_ready);
                check("status_done_cfg_inready",
                      int'({bus.init_done, bus.cfg_ready, bus.in_ready}),
                      int'({model_run, model_run, exp_rdy}));
                if (!model_run) check("init_out_valid", int'(bus.out_valid), 0);
            end
            // Handshakes seen now complete at the next rising edge.
            if (!rst) begin
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out: got %0d expected no beat (cycle %0d)",
                                 bus.out_data, cyc);
                    end else if (bus.out_ready) begin
                        e = exp_q.pop_front();
                        check("out_data", int'(bus.out_data), int'(e));
                        got_q.push_back(bus.out_data);
                        got_cyc.push_back(cyc);
                    end else begin
                        check("stall_hold", int'(bus.out_data), int'(exp_q[0]));
                    end
                end
                if (bus.in_valid && bus.in_ready) exp_q.push_back(model_tbl[bus.in_data]);
                if (model_run && bus.cfg_we) model_tbl[bus.cfg_addr] = bus.cfg_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [AW-1:0] a);
        int n = 0;
        bus.in_data  = a;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(posedge clk);
        #1;
        bus.cfg_we   = 1'b0;
    endtask

    // Call right after rst drops (#1 after the edge that sampled it high).
    task automatic wait_init();
        int n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.init_done || n >= 400) break;
        end
        check("init_cycles", n, DEPTH);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;

        // Reset, init timing; a cfg write and a waiting beat during INIT.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        fork
            wait_init();
            begin
                repeat (50) @(posedge clk);
                #1;
                cfg_write(8'h10, 2'b11);
                repeat (100) @(posedge clk);
                #1;
                bus.in_data  = 8'h30;
                bus.in_valid = 1'b1;
            end
        join
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        send(8'h10);
        drain();
        check("init_lookup_30", int'(got_q[0]), 1);
        check("init_ignored_cfg_10", int'(got_q[1]), 1);
        check("init_count", got_q.size(), 2);

        // Rewrite one entry, then a back-to-back stream.
        got_q.delete(); got_cyc.delete();
        cfg_write(8'h30, 2'b00);
        send(8'h30); send(8'h00); send(8'hFF);
        drain();
        check("b2b_0", int'(got_q[0]), 0);
        check("b2b_1", int'(got_q[1]), 1);
        check("b2b_2", int'(got_q[2]), 1);
        check("b2b_consec_a", got_cyc[1] - got_cyc[0], 1);
        check("b2b_consec_b", got_cyc[2] - got_cyc[1], 1);

        // Backpressure: first output stalls for 5 cycles.
        got_q.delete(); got_cyc.delete();
        bus.out_ready = 1'b0;
        send(8'h30);
        fork
            begin send(8'h00); send(8'h30); send(8'hFF); end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_data_stable", int'(bus.out_data), 0);
                    check("bp_in_ready_low", int'(bus.in_ready), 0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", got_q.size(), 4);
        check("bp_0", int'(got_q[0]), 0);
        check("bp_1", int'(got_q[1]), 1);
        check("bp_2", int'(got_q[2]), 0);
        check("bp_3", int'(got_q[3]), 1);

        // Same-cycle write and lookup of one address.
        got_q.delete(); got_cyc.delete();
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 8'h55;
        bus.cfg_data = 2'b10;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        send(8'h55);
        drain();
        check("hazard_old", int'(got_q[0]), 1);
        check("hazard_new", int'(got_q[1]), 2);

        // Reset while an output beat is pending; table returns to default.
        got_q.delete(); got_cyc.delete();
        bus.out_ready = 1'b0;
        send(8'h55);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_flush_valid", int'(bus.out_valid), 0);
        wait_init();
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(8'h55); send(8'h30);
        drain();
        check("reinit_55", int'(got_q[0]), 1);
        check("reinit_30", int'(got_q[1]), 1);
        check("reinit_count", got_q.size(), 2);

        // Randomised traffic with colliding writes and random backpressure.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.cfg_we    = ($urandom_range(0, 3) == 0);
            bus.cfg_addr  = {4'h5, 4'($urandom_range(0, 15))};
            bus.cfg_data  = 2'($urandom_range(0, 3));
            if (!bus.in_valid || acc) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = ($urandom_range(0, 3) != 0) ? {4'h5, 4'($urandom_range(0, 15))}
                                                           : 8'($urandom);
            end
        end
        bus.in_valid  = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
